dom_ascon_sbox_layer: RTL and testbench
=======================================

// Module: dom_ascon_sbox_layer
// PURPOSE
//   First-order (2-share) DOM-masked Ascon substitution layer over a full 5-lane state.
//   Applies the 5-bit Ascon S-box to all LANE_W bit-slices: PAR slices per cycle, LANE_W/PAR cycles.
//   Sits between the masked state register and the masked linear layer of the permutation round.
//   Share-domain separation and the fresh-randomness-per-AND rule are unchanged from the single S-box.
// PARAMETERS
//   LANE_W  64  bits per lane = number of S-boxes per layer
//   PAR     8   S-boxes evaluated per cycle; must divide LANE_W (elaboration error otherwise)
//   NB      LANE_W/PAR (localparam)  groups per layer
// PORTS
//   clk      in   1           clock, rising edge
//   rst      in   1           asynchronous, active-high reset
//   start    in   1           pulse: load ax_i/bx_i and begin a layer (ignored unless IDLE)
//   ax_i     in   5*LANE_W    share A of state; lane k = [k*LANE_W +: LANE_W]; lane 4 = x0, lane 0 = x4
//   bx_i     in   5*LANE_W    share B of state, same layout
//   rnd_i    in   5*PAR       fresh randomness: 5 bits per S-box (one per DOM AND), valid when rnd_req=1
//   rnd_req  out  1           randomness consumed at the next edge
//   busy     out  1           high from the cycle after start accept until done (inclusive)
//   done     out  1           one-cycle pulse: ay_o/by_o hold the complete result
//   ay_o     out  5*LANE_W    share A of result (state register A)
//   by_o     out  5*LANE_W    share B of result (state register B)
// BEHAVIOUR
//   S-box j input bit i = {ax_i,bx_i}[i*LANE_W + j]; bit 4 = x0 (MSB); unmasked S(x) = standard Ascon table.
//   Group g = slices g*PAR .. g*PAR+PAR-1; S-box p of a group uses rnd_i[5p +: 5], bit m -> DOM AND m.
//   Datapath per slice: linear pre-XORs -> 5 DOM ANDs (inner terms + resharing of cross terms with
//     rnd bit, registered) -> registered linear terms -> post-XORs incl. constant NOT on share A only.
//     One pipeline register stage (PAR wide); post-XOR output written back into state regs.
//   Share-B logic never combines share-A wires before the DOM register stage.
//   FSM states: IDLE, RUN, FLUSH, DONE; group counter cnt (clog2(NB) bits), pipe-valid flag pv.
//     IDLE : start=1 -> load state regs from ax_i/bx_i, cnt<=0, -> RUN. Otherwise outputs hold.
//     RUN  : rnd_req=1; edge: group cnt + rnd_i into pipe regs, pv<=1; if pv, write previous group back.
//            cnt==NB-1 -> FLUSH, else cnt<=cnt+1.
//     FLUSH: rnd_req=0; edge writes group NB-1 back, pv<=0 -> DONE.
//     DONE : done=1 for exactly this cycle; edge -> IDLE.
//   Timing: start sampled at edge E0; done high in cycle after edge E0+NB+1 (NB+2 cycles, 10 at defaults).
//   busy = (state != IDLE). rnd_req high exactly NB cycles per layer, consecutive.
//   start during RUN/FLUSH/DONE: ignored, no effect on result or timing.
//   start in the DONE->IDLE edge cycle is not sampled; start accepted only in IDLE.
//   Un-processed slices of the state are never modified except by their own write-back.
//   Reset (any time, incl. mid-layer): state regs, pipe regs, cnt, pv cleared to 0; FSM -> IDLE;
//     ay_o=by_o=0, busy=done=rnd_req=0. No partial result survives reset.
//   Result correctness independent of rnd_i value; security requires fresh uniform rnd_i each RUN cycle.
// TESTING
//   1. ax_i=bx_i=0, start -> done at cycle E0+10; ay_o^by_o lane 2 = all ones, other lanes 0 (S(0)=0x04).
//   2. Unmasked x_j = j mod 32 on slice j, random bx_i, random rnd_i -> every slice ay^by = S(x_j),
//      e.g. slice 1 = 0x0B, slice 31 = 0x17; repeat with 1000 random states vs. software model.
//   3. Same input, two different rnd_i streams -> identical unmasked result, differing shares.
//   4. start pulsed again during RUN and in DONE cycle -> ignored; single done pulse, result unchanged.
//   5. rst asserted asynchronously mid-RUN (cnt=3) -> outputs 0 immediately, FSM IDLE; new start runs clean.
//   6. PAR=LANE_W (NB=1) and PAR=1 (NB=64) -> done at E0+3 / E0+66, rnd_req width 1/64 cycles, correct output.

Source files
------------

// File: rtl/dom_ascon_sbox_layer.sv
// Two-share DOM-masked Ascon S-box layer: PAR bit-slices per cycle, one DOM register stage,
// results written back in place into the share-A / share-B state registers.

module dom_ascon_sbox_slice (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [4:0] i_xa,
  input  logic [4:0] i_xb,
  input  logic [4:0] i_rnd,
  output logic [4:0] o_ya,
  output logic [4:0] o_yb
);
  // w_a*/r_* are indexed by Ascon variable number (k = x_k); ports use bit order (bit 4 = x0)
  logic [4:0] w_aa, w_ab, w_ia, w_ib, w_ca, w_cb, w_ta, w_tb, w_ba, w_bb;
  logic [4:0] r_la, r_lb, r_ia, r_ib, r_ca, r_cb;

  always_comb begin
    w_aa = {i_xa[0] ^ i_xa[1], i_xa[1], i_xa[2] ^ i_xa[3], i_xa[3], i_xa[4] ^ i_xa[0]};
    w_ab = {i_xb[0] ^ i_xb[1], i_xb[1], i_xb[2] ^ i_xb[3], i_xb[3], i_xb[4] ^ i_xb[0]};
  end

  // AND k computes ~a_k & a_{k+1}; the complement is applied to share A only
  for (genvar k = 0; k < 5; k++) begin : g_and
    localparam int K1 = (k + 1) % 5;
    assign w_ia[k] = ~w_aa[k] & w_aa[K1];
    assign w_ca[k] = (~w_aa[k] & w_ab[K1]) ^ i_rnd[k];
    assign w_ib[k] = w_ab[k] & w_ab[K1];
    assign w_cb[k] = (w_ab[k] & w_aa[K1]) ^ i_rnd[k];
    assign w_ta[k] = r_ia[k] ^ r_ca[k];
    assign w_tb[k] = r_ib[k] ^ r_cb[k];
    assign w_ba[k] = r_la[k] ^ w_ta[K1];
    assign w_bb[k] = r_lb[k] ^ w_tb[K1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_la <= '0; r_lb <= '0; r_ia <= '0; r_ib <= '0; r_ca <= '0; r_cb <= '0;
    end else if (i_en) begin
      r_la <= w_aa; r_lb <= w_ab;
      r_ia <= w_ia; r_ib <= w_ib;
      r_ca <= w_ca; r_cb <= w_cb;
    end
  end

  assign o_ya = {w_ba[0] ^ w_ba[4], w_ba[1] ^ w_ba[0], ~w_ba[2], w_ba[3] ^ w_ba[2], w_ba[4]};
  assign o_yb = {w_bb[0] ^ w_bb[4], w_bb[1] ^ w_bb[0],  w_bb[2], w_bb[3] ^ w_bb[2], w_bb[4]};
endmodule

module dom_ascon_sbox_layer #(
  parameter int LANE_W = 64,
  parameter int PAR    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [5*LANE_W-1:0] ax_i,
  input  logic [5*LANE_W-1:0] bx_i,
  input  logic [5*PAR-1:0]    rnd_i,
  output logic                rnd_req,
  output logic                busy,
  output logic                done,
  output logic [5*LANE_W-1:0] ay_o,
  output logic [5*LANE_W-1:0] by_o
);
  localparam int NB = LANE_W / PAR;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  if (LANE_W % PAR != 0) begin : g_chk
    $error("PAR must divide LANE_W");
  end

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                     r_state;
  logic [CW-1:0]              r_cnt, w_wg;
  logic                       r_pv, w_pen;
  logic [5*LANE_W-1:0]        r_ax, r_bx;
  logic [4:0][PAR-1:0]        w_ga, w_gb, w_ya, w_yb;

  assign w_pen = (r_state == RUN);
  // Group in the pipe: one behind cnt while running, cnt itself once cnt has stopped at NB-1
  assign w_wg  = (r_state == FLUSH) ? r_cnt : r_cnt - CW'(1);

  always_comb begin
    for (int l = 0; l < 5; l++) begin
      w_ga[l] = r_ax[l*LANE_W + int'(r_cnt)*PAR +: PAR];
      w_gb[l] = r_bx[l*LANE_W + int'(r_cnt)*PAR +: PAR];
    end
  end

  for (genvar p = 0; p < PAR; p++) begin : g_sl
    logic [4:0] w_xa, w_xb, w_oa, w_ob;
    for (genvar l = 0; l < 5; l++) begin : g_ln
      assign w_xa[l]    = w_ga[l][p];
      assign w_xb[l]    = w_gb[l][p];
      assign w_ya[l][p] = w_oa[l];
      assign w_yb[l][p] = w_ob[l];
    end
    dom_ascon_sbox_slice u_sl (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_pen),
      .i_xa  (w_xa),
      .i_xb  (w_xb),
      .i_rnd (rnd_i[5*p +: 5]),
      .o_ya  (w_oa),
      .o_yb  (w_ob)
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pv    <= 1'b0;
      r_ax    <= '0;
      r_bx    <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_ax    <= ax_i;
          r_bx    <= bx_i;
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_pv <= 1'b1;
          if (r_pv) begin
            for (int l = 0; l < 5; l++) begin
              r_ax[l*LANE_W + int'(w_wg)*PAR +: PAR] <= w_ya[l];
              r_bx[l*LANE_W + int'(w_wg)*PAR +: PAR] <= w_yb[l];
            end
          end
          if (r_cnt == CW'(NB - 1)) r_state <= FLUSH;
          else                      r_cnt   <= r_cnt + CW'(1);
        end
        FLUSH: begin
          for (int l = 0; l < 5; l++) begin
            r_ax[l*LANE_W + int'(w_wg)*PAR +: PAR] <= w_ya[l];
            r_bx[l*LANE_W + int'(w_wg)*PAR +: PAR] <= w_yb[l];
          end
          r_pv    <= 1'b0;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rnd_req = (r_state == RUN);
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign ay_o    = r_ax;
  assign by_o    = r_bx;
endmodule

// File: tb/tb_dom_ascon_sbox_layer.sv
// Directed bench for the masked Ascon S-box layer: three instances (NB=8, NB=1, NB=64)
// checked against the Ascon S-box table, latency and handshake expectations.

module tb_dom_ascon_sbox_layer;
  localparam int LW = 64;
  localparam int N  = 5*LW;

  localparam logic [4:0] SB [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic clk = 1'b0;
  logic rst, st_m, st_x, rz;
  logic [N-1:0] ax, bx;
  logic [39:0]  rnd_m;
  logic [319:0] rnd_w;
  logic [4:0]   rnd_n;
  logic [2:0]   req, bsy, dn;
  logic [N-1:0] ya [3];
  logic [N-1:0] yb [3];

  int n_chk = 0, n_fail = 0;
  int kd [3], nreq [3], ndone [3];
  logic [N-1:0] res_a [3], res_b [3];

  always #5 clk = ~clk;

  dom_ascon_sbox_layer #(.LANE_W(LW), .PAR(8)) u_m (
    .clk(clk), .rst(rst), .start(st_m), .ax_i(ax), .bx_i(bx), .rnd_i(rnd_m),
    .rnd_req(req[0]), .busy(bsy[0]), .done(dn[0]), .ay_o(ya[0]), .by_o(yb[0]));
  dom_ascon_sbox_layer #(.LANE_W(LW), .PAR(64)) u_w (
    .clk(clk), .rst(rst), .start(st_x), .ax_i(ax), .bx_i(bx), .rnd_i(rnd_w),
    .rnd_req(req[1]), .busy(bsy[1]), .done(dn[1]), .ay_o(ya[1]), .by_o(yb[1]));
  dom_ascon_sbox_layer #(.LANE_W(LW), .PAR(1)) u_n (
    .clk(clk), .rst(rst), .start(st_x), .ax_i(ax), .bx_i(bx), .rnd_i(rnd_n),
    .rnd_req(req[2]), .busy(bsy[2]), .done(dn[2]), .ay_o(ya[2]), .by_o(yb[2]));

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model(input logic [N-1:0] x);
    logic [N-1:0] r;
    logic [4:0] v, s;
    r = '0;
    for (int j = 0; j < LW; j++) begin
      for (int i = 0; i < 5; i++) v[i] = x[i*LW + j];
      s = SB[v];
      for (int i = 0; i < 5; i++) r[i*LW + j] = s[i];
    end
    return r;
  endfunction

  function automatic logic [4:0] slice(input logic [N-1:0] x, input int j);
    logic [4:0] v;
    for (int i = 0; i < 5; i++) v[i] = x[i*LW + j];
    return v;
  endfunction

  task automatic drive_rnd();
    rnd_m = rz ? '0 : 40'({$urandom, $urandom});
    for (int i = 0; i < 10; i++) rnd_w[i*32 +: 32] = rz ? 32'h0 : $urandom;
    rnd_n = rz ? 5'h0 : 5'($urandom);
  endtask

  // Fixed 81-cycle window: long enough for the NB=64 instance, bounded in every case
  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b, input bit also_x, input bit pulse);
    int k;
    @(negedge clk);
    ax = a; bx = b; st_m = 1'b1; st_x = also_x;
    drive_rnd();
    for (int i = 0; i < 3; i++) begin kd[i] = -1; nreq[i] = 0; ndone[i] = 0; end
    @(negedge clk);
    st_m = 1'b0; st_x = 1'b0; k = 0;
    while (k <= 80) begin
      drive_rnd();
      for (int i = 0; i < 3; i++) begin
        if (req[i]) nreq[i]++;
        if (dn[i]) begin
          ndone[i]++;
          if (kd[i] < 0) begin kd[i] = k; res_a[i] = ya[i]; res_b[i] = yb[i]; end
        end
      end
      st_m = pulse && (k == 3 || dn[0]);
      @(negedge clk);
      k++;
    end
    st_m = 1'b0;
  endtask

  logic [N-1:0] x, b, e, pa;

  initial begin
    rst = 1'b1; st_m = 1'b0; st_x = 1'b0; rz = 1'b0; ax = '0; bx = '0;
    drive_rnd();
    repeat (2) @(negedge clk);
    chk("rst_ay", ya[0], '0);
    chk("rst_by", yb[0], '0);
    chk("rst_ctl", {req[0], bsy[0], dn[0]}, '0);
    rst = 1'b0;

    // all-zero state, zero randomness: S(0)=0x04 puts ones in lane 2 only
    rz = 1'b1;
    e = '0; e[2*LW +: LW] = '1;
    run('0, '0, 1'b1, 1'b0);
    rz = 1'b0;
    chk("zero_nb8", res_a[0] ^ res_b[0], e);
    chk("zero_nb1", res_a[1] ^ res_b[1], e);
    chk("zero_nb64", res_a[2] ^ res_b[2], e);
    chk("lat_nb8", kd[0], 9);
    chk("lat_nb1", kd[1], 2);
    chk("lat_nb64", kd[2], 65);
    chk("req_nb8", nreq[0], 8);
    chk("req_nb1", nreq[1], 1);
    chk("req_nb64", nreq[2], 64);
    chk("done_cnt", ndone[0] + ndone[1] + ndone[2], 3);

    // slice j carries j mod 32, masked with random share B
    x = '0;
    for (int j = 0; j < LW; j++)
      for (int i = 0; i < 5; i++) x[i*LW + j] = ((j % 32) >> i) & 1;
    for (int i = 0; i < 10; i++) b[i*32 +: 32] = $urandom;
    e = model(x);
    run(x ^ b, b, 1'b1, 1'b0);
    chk("ramp_nb8", res_a[0] ^ res_b[0], e);
    chk("ramp_nb1", res_a[1] ^ res_b[1], e);
    chk("ramp_nb64", res_a[2] ^ res_b[2], e);
    chk("slice1", slice(res_a[0] ^ res_b[0], 1), 5'h0b);
    chk("slice31", slice(res_a[0] ^ res_b[0], 31), 5'h17);
    chk("slice0", slice(res_a[2] ^ res_b[2], 0), 5'h04);
    pa = res_a[0];

    // same input, fresh randomness: same value, different sharing
    run(x ^ b, b, 1'b0, 1'b0);
    chk("rerun_val", res_a[0] ^ res_b[0], e);
    chk("rerun_shr", (res_a[0] != pa), 1);

    // start pulsed mid-RUN and in the DONE cycle must be ignored
    run(x ^ b, b, 1'b0, 1'b1);
    chk("pulse_val", res_a[0] ^ res_b[0], e);
    chk("pulse_lat", kd[0], 9);
    chk("pulse_done", ndone[0], 1);
    chk("pulse_idle", bsy[0], 0);

    // asynchronous reset while cnt=3
    @(negedge clk);
    ax = x ^ b; bx = b; st_m = 1'b1;
    @(negedge clk);
    st_m = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ay", ya[0], '0);
    chk("arst_by", yb[0], '0);
    chk("arst_ctl", {req[0], bsy[0], dn[0]}, '0);
    @(negedge clk);
    rst = 1'b0;
    x = '1;
    e = '0; e[0 +: LW] = '1; e[LW +: LW] = '1; e[2*LW +: LW] = '1; e[4*LW +: LW] = '1;
    run(x ^ b, b, 1'b0, 1'b0);
    chk("post_rst", res_a[0] ^ res_b[0], e);
    chk("post_lat", kd[0], 9);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 10; i++) begin x[i*32 +: 32] = $urandom; b[i*32 +: 32] = $urandom; end
      run(x ^ b, b, 1'b0, 1'b0);
      chk("rand", res_a[0] ^ res_b[0], model(x));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
